vga_sync_decoder: RTL and testbench

//  Receive-side counterpart of the VGA timing generator. Samples HS/VS/BLANK_N/G from the video

---
 rtl/vga_sync_decoder_if.sv | 12 +
 rtl/vga_sync_decoder.sv | 181 ++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_decoder_if.sv
// Video output bus between the VGA timing generator (master) and a receive-side
// capture/self-check block (slave).
interface vga_sync_decoder_if;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic [7:0] VGA_G;

  modport master (output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_G);
  modport slave  (input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_G);
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing checker: recovers active-area coordinates, measures line/frame
// timing, locks after consecutive good frames and counts lit pixels per frame.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  vga_sync_decoder_if.slave   vga,
  input  logic                err_clear,
  output logic [9:0]          cap_x,
  output logic [8:0]          cap_y,
  output logic                cap_pixel,
  output logic                cap_valid,
  output logic [10:0]         line_len,
  output logic [10:0]         frame_lines,
  output logic [18:0]         lit_count,
  output logic                frame_done,
  output logic                locked,
  output logic                timing_err
);

  localparam logic [10:0] H_TOTAL_L  = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_L  = 11'(V_TOTAL);
  localparam logic [10:0] H_ACTIVE_L = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACTIVE_L = 10'(V_ACTIVE);
  localparam logic [3:0]  LOCK_L     = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state_reg;
  logic        vclk_s_reg, hs_s_reg, vs_s_reg, blank_s_reg;
  logic [7:0]  g_s_reg;
  logic        hs_prev_reg, vs_prev_reg, blank_prev_reg;
  logic [10:0] h_cnt_reg, v_cnt_reg;
  logic [18:0] acc_reg;
  logic        seen_hs_reg, frame_bad_reg;
  logic [3:0]  good_cnt_reg;

  logic hs_fall, vs_fall, active, run_start, run_end, lit;
  logic line_bad, run_bad, frame_good;

  // Edges are taken between consecutive samples, never between raw clock cycles.
  always_comb begin
    hs_fall    = vclk_s_reg & hs_prev_reg & ~hs_s_reg;
    vs_fall    = vclk_s_reg & vs_prev_reg & ~vs_s_reg;
    active     = vclk_s_reg & blank_s_reg;
    run_start  = active & ~blank_prev_reg;
    run_end    = vclk_s_reg & blank_prev_reg & ~blank_s_reg;
    lit        = |g_s_reg;
    line_bad   = hs_fall & seen_hs_reg & ((h_cnt_reg + 11'd1) != H_TOTAL_L);
    run_bad    = run_end & (({1'b0, cap_x} + 11'd1) != H_ACTIVE_L);
    frame_good = ~frame_bad_reg & ~line_bad & ~run_bad
               & (v_cnt_reg == V_TOTAL_L)
               & (({1'b0, cap_y} + {9'd0, run_end}) == V_ACTIVE_L);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg      <= SEARCH;
      vclk_s_reg     <= 1'b0;
      hs_s_reg       <= 1'b0;
      vs_s_reg       <= 1'b0;
      blank_s_reg    <= 1'b0;
      g_s_reg        <= 8'd0;
      hs_prev_reg    <= 1'b0;
      vs_prev_reg    <= 1'b0;
      blank_prev_reg <= 1'b0;
      h_cnt_reg      <= 11'd0;
      v_cnt_reg      <= 11'd0;
      acc_reg        <= 19'd0;
      seen_hs_reg    <= 1'b0;
      frame_bad_reg  <= 1'b0;
      good_cnt_reg   <= 4'd0;
      cap_x          <= 10'd0;
      cap_y          <= 9'd0;
      cap_pixel      <= 1'b0;
      cap_valid      <= 1'b0;
      line_len       <= 11'd0;
      frame_lines    <= 11'd0;
      lit_count      <= 19'd0;
      frame_done     <= 1'b0;
      locked         <= 1'b0;
      timing_err     <= 1'b0;
    end else begin
      vclk_s_reg  <= vga.VGA_CLK;
      hs_s_reg    <= vga.VGA_HS;
      vs_s_reg    <= vga.VGA_VS;
      blank_s_reg <= vga.VGA_BLANK_N;
      g_s_reg     <= vga.VGA_G;
      frame_done  <= 1'b0;
      cap_valid   <= 1'b0;
      if (err_clear)
        timing_err <= 1'b0;

      if (vclk_s_reg) begin
        hs_prev_reg    <= hs_s_reg;
        vs_prev_reg    <= vs_s_reg;
        blank_prev_reg <= blank_s_reg;

        if (hs_fall) begin
          h_cnt_reg   <= 11'd0;
          line_len    <= h_cnt_reg + 11'd1;
          seen_hs_reg <= 1'b1;
        end else if (h_cnt_reg != 11'h7FF) begin
          h_cnt_reg <= h_cnt_reg + 11'd1;
        end

        if (vs_fall)
          v_cnt_reg <= {10'd0, hs_fall};
        else if (hs_fall && v_cnt_reg != 11'h7FF)
          v_cnt_reg <= v_cnt_reg + 11'd1;

        if (active) begin
          cap_valid <= 1'b1;
          cap_pixel <= lit;
          if (run_start)
            cap_x <= 10'd0;
          else if (cap_x != 10'h3FF)
            cap_x <= cap_x + 10'd1;
        end

        if (vs_fall)
          cap_y <= 9'd0;
        else if (run_end && cap_y != 9'h1FF)
          cap_y <= cap_y + 9'd1;

        if (vs_fall) begin
          lit_count     <= acc_reg;
          acc_reg       <= 19'd0;
          frame_lines   <= v_cnt_reg;
          frame_bad_reg <= 1'b0;
        end else begin
          if (active && lit && acc_reg != 19'h7FFFF)
            acc_reg <= acc_reg + 19'd1;
          if (line_bad || run_bad)
            frame_bad_reg <= 1'b1;
        end

        // The frame just closed is judged here; the error set overrides err_clear above.
        if (vs_fall) begin
          case (state_reg)
            SEARCH: begin
              state_reg    <= MEASURE;
              good_cnt_reg <= 4'd0;
            end
            MEASURE: begin
              frame_done <= 1'b1;
              if (frame_good) begin
                good_cnt_reg <= good_cnt_reg + 4'd1;
                if (good_cnt_reg + 4'd1 == LOCK_L) begin
                  state_reg <= LOCKED;
                  locked    <= 1'b1;
                end
              end else begin
                good_cnt_reg <= 4'd0;
              end
            end
            LOCKED: begin
              frame_done <= 1'b1;
              if (!frame_good) begin
                timing_err   <= 1'b1;
                locked       <= 1'b0;
                state_reg    <= MEASURE;
                good_cnt_reg <= 4'd0;
              end
            end
            default: begin
              state_reg <= SEARCH;
              locked    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomised frame-level check of vga_sync_decoder using a reduced raster so several
// frames fit in a short run; expectations come from what the bench itself generated.
module tb_vga_sync_decoder;
  localparam int H_TOTAL  = 24;
  localparam int H_ACTIVE = 16;
  localparam int V_TOTAL  = 12;
  localparam int V_ACTIVE = 8;
  localparam int LOCK_FRAMES = 2;
  localparam int HS_W = 3;
  localparam int H_BP = 5;
  localparam int VS_W = 2;
  localparam int V_BP = 3;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        err_clear;
  logic [9:0]  cap_x;
  logic [8:0]  cap_y;
  logic        cap_pixel, cap_valid;
  logic [10:0] line_len, frame_lines;
  logic [18:0] lit_count;
  logic        frame_done, locked, timing_err;

  vga_sync_decoder_if bus ();

  vga_sync_decoder #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .vga(bus), .err_clear(err_clear),
    .cap_x(cap_x), .cap_y(cap_y), .cap_pixel(cap_pixel), .cap_valid(cap_valid),
    .line_len(line_len), .frame_lines(frame_lines), .lit_count(lit_count),
    .frame_done(frame_done), .locked(locked), .timing_err(timing_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       p;
  } px_t;

  px_t exp_q[$];
  px_t mon_e;
  int  tests = 0;
  int  fails = 0;
  int  pulses = 0;

  // Reference state, kept in terms of what was generated on the bus.
  int m_lines, m_lit, m_runs, m_px, m_x, m_prev_len, m_last_len;
  int m_state, m_good;
  bit m_bad, m_have_line, m_in_run, m_err, clear_at_close;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle_noise();
    bus.VGA_CLK     = 1'b0;
    bus.VGA_HS      = 1'($urandom);
    bus.VGA_VS      = 1'($urandom);
    bus.VGA_BLANK_N = 1'($urandom);
    bus.VGA_G       = 8'($urandom);
    tick();
  endtask

  task automatic send_sample(input logic hs, input logic vs, input logic bl, input logic [7:0] g);
    int n;
    n = $urandom_range(2, 0);
    for (int i = 0; i < n; i++) idle_noise();
    bus.VGA_CLK     = 1'b1;
    bus.VGA_HS      = hs;
    bus.VGA_VS      = vs;
    bus.VGA_BLANK_N = bl;
    bus.VGA_G       = g;
    tick();
    bus.VGA_CLK = 1'b0;
  endtask

  function automatic logic [7:0] pix_g(input int pat, input int x, input int y);
    case (pat)
      0:       return 8'($urandom_range(255, 1));
      1:       return (((x + y) % 2) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
      default: return ($urandom_range(1, 0) == 1) ? 8'($urandom_range(255, 1)) : 8'd0;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_cap"}, 32'({cap_x, cap_y, cap_pixel, cap_valid}), 32'd0);
    chk({tag, "_line_len"}, 32'(line_len), 32'd0);
    chk({tag, "_frame_lines"}, 32'(frame_lines), 32'd0);
    chk({tag, "_lit_count"}, 32'(lit_count), 32'd0);
    chk({tag, "_flags"}, 32'({frame_done, locked, timing_err}), 32'd0);
  endtask

  task automatic do_reset();
    repeat (3) idle_noise();
    reset = 1'b1;
    #2;
    check_all_zero("reset");
    tick();
    tick();
    reset = 1'b0;
    m_lines = 0; m_lit = 0; m_runs = 0; m_px = 0; m_x = 0;
    m_bad = 0; m_have_line = 0; m_in_run = 0;
    m_state = 0; m_good = 0; m_err = 0;
    pulses = 0;
    exp_q.delete();
  endtask

  task automatic close_frame();
    bit good, set_now, exp_done;
    good     = !m_bad && m_lines == V_TOTAL && m_runs == V_ACTIVE;
    exp_done = (m_state != 0);
    set_now  = 0;
    case (m_state)
      0: begin m_state = 1; m_good = 0; end
      1: begin
        if (good) begin
          m_good++;
          if (m_good == LOCK_FRAMES) m_state = 2;
        end else begin
          m_good = 0;
        end
      end
      default: begin
        if (!good) begin set_now = 1; m_state = 1; m_good = 0; end
      end
    endcase
    if (set_now) m_err = 1;
    else if (clear_at_close) m_err = 0;
    if (clear_at_close) err_clear = 1'b1;
    idle_noise();
    chk("frame_done", 32'(frame_done), 32'(exp_done));
    chk("frame_lines", 32'(frame_lines), 32'(m_lines));
    chk("line_len", 32'(line_len), 32'(m_last_len));
    chk("lit_count", 32'(lit_count), 32'(m_lit));
    chk("locked", 32'(locked), 32'(m_state == 2));
    chk("timing_err", 32'(timing_err), 32'(m_err));
    chk("cap_valid_pulses", 32'(pulses), 32'(m_px));
    $display("[TB] frame closed: lines=%0d lit=%0d good=%0d locked=%0b err=%0b",
             m_lines, m_lit, good, locked, timing_err);
    err_clear = 1'b0;
    clear_at_close = 0;
    idle_noise();
    chk("frame_done_single", 32'(frame_done), 32'd0);
    m_lines = 0; m_lit = 0; m_runs = 0; m_px = 0; m_bad = 0;
    pulses = 0;
  endtask

  task automatic send_line(input int v, input int len, input int pat, input bit gap,
                           input int start_h, input int rst_h);
    for (int h = start_h; h < len; h++) begin
      logic       hs, vs, act;
      logic [7:0] g;
      px_t        e;
      if (h == rst_h) do_reset();
      hs  = (h < HS_W) ? 1'b0 : 1'b1;
      vs  = (v < VS_W) ? 1'b0 : 1'b1;
      act = (v >= V_BP && v < V_BP + V_ACTIVE && h >= H_BP && h < H_BP + H_ACTIVE);
      g   = act ? pix_g(pat, h - H_BP, v - V_BP) : 8'($urandom);
      if (h == 0) begin
        if (m_have_line) begin
          m_last_len = m_prev_len;
          if (m_prev_len != H_TOTAL) m_bad = 1;
        end
      end
      if (act) begin
        if (!m_in_run) m_x = 0;
        else m_x++;
        m_in_run = 1;
        e.x = 10'(m_x);
        e.y = 9'(m_runs);
        e.p = (g != 8'd0);
        exp_q.push_back(e);
        m_px++;
        if (g != 8'd0) m_lit++;
      end else if (m_in_run) begin
        m_runs++;
        m_in_run = 0;
      end
      send_sample(hs, vs, act, g);
      if (h == 0) begin
        if (v == 0) close_frame();
        m_lines++;
        m_have_line = 1;
      end
      if (gap && h == 10) repeat (100) idle_noise();
    end
    m_prev_len = len;
  endtask

  task automatic send_frame(input int first_v, input int pat, input int bad_v, input int bad_len,
                            input int gap_v, input int start_h, input int rst_v, input int rst_h);
    for (int v = first_v; v < V_TOTAL; v++)
      send_line(v, (v == bad_v) ? bad_len : H_TOTAL, pat, v == gap_v,
                (v == first_v) ? start_h : 0, (v == rst_v) ? rst_h : -1);
  endtask

  always @(negedge CLOCK_50) begin
    if (!reset && cap_valid) begin
      pulses++;
      chk("cap_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("cap_x", 32'(cap_x), 32'(mon_e.x));
        chk("cap_y", 32'(cap_y), 32'(mon_e.y));
        chk("cap_pixel", 32'(cap_pixel), 32'(mon_e.p));
      end
    end
  end

  initial begin
    reset = 1'b1;
    err_clear = 1'b0;
    clear_at_close = 0;
    bus.VGA_CLK = 1'b0; bus.VGA_HS = 1'b1; bus.VGA_VS = 1'b1;
    bus.VGA_BLANK_N = 1'b0; bus.VGA_G = 8'd0;
    m_prev_len = 0; m_last_len = 0;
    do_reset();

    send_frame(4, 2, -1, 0, -1, 8, -1, -1);             // partial frame, unchecked
    send_frame(0, 0, -1, 0, -1, 0, -1, -1);             // all lit
    send_frame(0, 1, -1, 0, -1, 0, -1, -1);             // checkerboard
    send_frame(0, 2, -1, 0, -1, 0, -1, -1);             // random
    send_frame(0, 2, -1, 0, 5, 0, -1, -1);              // long VGA_CLK gap mid-line
    send_frame(0, 2, 7, H_TOTAL + 1, -1, 0, -1, -1);    // one long line while locked
    send_frame(0, 0, -1, 0, -1, 0, -1, -1);
    send_frame(0, 1, -1, 0, -1, 0, -1, -1);
    send_frame(0, 2, 11, H_TOTAL + 1, -1, 0, -1, -1);   // long line ending on the VS fall
    clear_at_close = 1;                                 // clear coincides with a new error
    send_frame(0, 2, -1, 0, -1, 0, -1, -1);

    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    m_err = 0;
    tick();
    chk("err_clear", 32'(timing_err), 32'd0);

    send_frame(0, 2, -1, 0, -1, 0, -1, -1);
    send_frame(0, 2, -1, 0, -1, 0, 5, 12);              // reset mid-line, mid-frame
    send_frame(0, 1, -1, 0, -1, 0, -1, -1);
    send_frame(0, 0, -1, 0, -1, 0, -1, -1);
    send_frame(0, 2, -1, 0, -1, 0, -1, -1);
    send_line(0, H_TOTAL, 0, 0, 0, -1);
    repeat (3) idle_noise();
    chk("cap_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
